// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and default widths for the clock-divider controller.
package clk_div_ctrl_pkg;

  localparam int DEF_RATIO_WIDTH = 32;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake and status bundle of the clock-divider controller.
interface clk_div_ctrl_if #(
  parameter int RATIO_WIDTH = clk_div_ctrl_pkg::DEF_RATIO_WIDTH,
  parameter int COUNT_WIDTH = clk_div_ctrl_pkg::DEF_COUNT_WIDTH
);
  logic                   cfg_valid_i;
  logic                   cfg_ready_o;
  logic [RATIO_WIDTH-1:0] cfg_ratio_i;
  logic [COUNT_WIDTH-1:0] cfg_count_i;
  logic                   stop_i;
  logic                   tick_o;
  logic                   busy_o;
  logic                   done_o;
  logic [COUNT_WIDTH-1:0] tick_cnt_o;

  // Controller side
  modport slave (
    input  cfg_valid_i, cfg_ratio_i, cfg_count_i, stop_i,
    output cfg_ready_o, tick_o, busy_o, done_o, tick_cnt_o
  );

  // Requester side
  modport master (
    output cfg_valid_i, cfg_ratio_i, cfg_count_i, stop_i,
    input  cfg_ready_o, tick_o, busy_o, done_o, tick_cnt_o
  );
endinterface

// File: rtl/clk_div_ctrl_tick_div.sv
// Free-running ratio divider: pulses tick_o on the cycle the counter hits ratio-1.
module tick_div #(
  parameter int RATIO_WIDTH = clk_div_ctrl_pkg::DEF_RATIO_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [RATIO_WIDTH-1:0] ratio_i,
  output logic                   tick_o
);

  logic [RATIO_WIDTH-1:0] cnt_q;

  // ratio_i is never 0 here (clamped upstream), so ratio-1 cannot underflow
  assign tick_o = en_i && (cnt_q == ratio_i - RATIO_WIDTH'(1));

  // Count enabled cycles, wrapping to 0 on each tick
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      cnt_q <= '0;
    else if (clr_i)   cnt_q <= '0;
    else if (en_i)    cnt_q <= tick_o ? '0 : cnt_q + RATIO_WIDTH'(1);
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencer that emits a configured number of divided ticks (or runs until stopped).
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int RATIO_WIDTH = DEF_RATIO_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  clk_div_ctrl_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] tick_cnt_q;
  logic                   div_en, div_clr, tick;
  logic                   accept, last_tick;
  logic                   ready, done;

  // Divider only runs in RUN; gating with rst_ni suppresses a tick in the reset cycle
  assign div_en  = (state_q == ST_RUN) && rst_ni;
  assign div_clr = (state_q == ST_LOAD);

  tick_div #(.RATIO_WIDTH(RATIO_WIDTH)) u_div (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (div_en),
    .clr_i   (div_clr),
    .ratio_i (ratio_q),
    .tick_o  (tick)
  );

  assign accept    = bus.cfg_valid_i && ready;
  assign last_tick = tick && (count_q != '0) &&
                     (COUNT_WIDTH'(tick_cnt_q + COUNT_WIDTH'(1)) == count_q);

  // Next-state and per-state strobes
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.cfg_valid_i) state_d = ST_LOAD;
      end
      ST_LOAD:   state_d = ST_RUN;
      ST_RUN:    if (bus.stop_i || last_tick) state_d = ST_FINISH;
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register plus latched configuration and tick counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ratio_q    <= '0;
      count_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ratio_q    <= (bus.cfg_ratio_i == '0) ? RATIO_WIDTH'(1) : bus.cfg_ratio_i;
        count_q    <= bus.cfg_count_i;
        tick_cnt_q <= '0;
      end else if (tick) begin
        tick_cnt_q <= tick_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.cfg_ready_o = ready;
  assign bus.tick_o      = tick;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done && rst_ni;
  assign bus.tick_cnt_o  = tick_cnt_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench: vector table of sequences with a tick-cycle scoreboard,
// plus hand-written reset and counter-wrap sequences.
module tb_clk_div_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.RATIO_WIDTH(32), .COUNT_WIDTH(16)) c1 ();
  clk_div_ctrl_if #(.RATIO_WIDTH(32), .COUNT_WIDTH(4))  c2 ();

  clk_div_ctrl #(.RATIO_WIDTH(32), .COUNT_WIDTH(16)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(c1));
  clk_div_ctrl #(.RATIO_WIDTH(32), .COUNT_WIDTH(4))  dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(c2));

  int nchk = 0;
  int nerr = 0;
  int exp_q[$];   // expected tick cycles, relative to the acceptance edge

  typedef struct {
    string       nm;
    logic [31:0] ratio;
    logic [15:0] count;
    int          stop_k;   // stop_i on this tick number, 0 = never
    int          n_exp;    // expected number of ticks
    bit          hold;     // raise cfg_valid_i mid-RUN with ratio 2 / count 1
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
  task automatic run_seq(input vec_t v);
    int  reff, ticks, exp_done;
    bit  finished;
    reff     = (v.ratio == 0) ? 1 : int'(v.ratio);
    ticks    = 0;
    finished = 0;
    exp_done = 2 + v.n_exp * reff;
    chk({v.nm, " ready_idle"}, 32'(c1.cfg_ready_o), 32'd1);
    c1.cfg_valid_i = 1'b1;
    c1.cfg_ratio_i = v.ratio;
    c1.cfg_count_i = v.count;
    exp_q.delete();
    for (int k = 1; k <= v.n_exp; k++) exp_q.push_back(1 + k * reff);
    @(posedge clk);
    for (int rel = 1; rel <= 400; rel++) begin
      @(negedge clk);
      c1.stop_i = 1'b0;
      if (rel == 1) begin
        c1.cfg_valid_i = 1'b0;
        chk({v.nm, " load_busy"},  32'(c1.busy_o), 32'd1);
        chk({v.nm, " load_ready"}, 32'(c1.cfg_ready_o), 32'd0);
        chk({v.nm, " load_cnt"},   32'(c1.tick_cnt_o), 32'd0);
      end
      if (v.hold && rel == 3) begin
        c1.cfg_valid_i = 1'b1;
        c1.cfg_ratio_i = 32'd2;
        c1.cfg_count_i = 16'd1;
      end
      if (rel > 1 && !c1.done_o && c1.cfg_ready_o) chk({v.nm, " ready_busy"}, 32'(c1.cfg_ready_o), 32'd0);
      if (c1.tick_o) begin
        ticks++;
        if (exp_q.size() == 0) chk({v.nm, " extra_tick_at"}, 32'(rel), 32'd0);
        else chk({v.nm, " tick_cycle"}, 32'(rel), 32'(exp_q.pop_front()));
        if (v.stop_k != 0 && ticks == v.stop_k) c1.stop_i = 1'b1;
      end
      if (c1.done_o) begin
        chk({v.nm, " done_cycle"}, 32'(rel), 32'(exp_done));
        chk({v.nm, " done_cnt"},   32'(c1.tick_cnt_o), 32'(v.n_exp));
        finished = 1;
        break;
      end
    end
    c1.stop_i = 1'b0;
    if (!finished) chk({v.nm, " timeout"}, 32'd0, 32'd1);
    chk({v.nm, " missing_ticks"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk({v.nm, " post_ready"}, 32'(c1.cfg_ready_o), 32'd1);
    chk({v.nm, " post_busy"},  32'(c1.busy_o), 32'd0);
    chk({v.nm, " post_done"},  32'(c1.done_o), 32'd0);
    chk({v.nm, " post_tick"},  32'(c1.tick_o), 32'd0);
    chk({v.nm, " post_cnt"},   32'(c1.tick_cnt_o), 32'(v.n_exp));
  endtask

  initial begin
    int t;
    vecs[0] = '{"r4c3",      32'd4, 16'd3, 0, 3, 1'b0};
    vecs[1] = '{"r0c5",      32'd0, 16'd5, 0, 5, 1'b0};
    vecs[2] = '{"r3stop7",   32'd3, 16'd0, 7, 7, 1'b0};
    vecs[3] = '{"r6c2hold",  32'd6, 16'd2, 0, 2, 1'b1};
    vecs[4] = '{"r2c1new",   32'd2, 16'd1, 0, 1, 1'b0};
    vecs[5] = '{"r1c1",      32'd1, 16'd1, 0, 1, 1'b0};
    vecs[6] = '{"r1stop1",   32'd1, 16'd0, 1, 1, 1'b0};
    vecs[7] = '{"r7c2stop2", 32'd7, 16'd9, 2, 2, 1'b0};

    c1.cfg_valid_i = 1'b0; c1.cfg_ratio_i = '0; c1.cfg_count_i = '0; c1.stop_i = 1'b0;
    c2.cfg_valid_i = 1'b0; c2.cfg_ratio_i = '0; c2.cfg_count_i = '0; c2.stop_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(c1.cfg_ready_o), 32'd1);
    chk("rst_busy",  32'(c1.busy_o), 32'd0);
    chk("rst_done",  32'(c1.done_o), 32'd0);
    chk("rst_tick",  32'(c1.tick_o), 32'd0);
    chk("rst_cnt",   32'(c1.tick_cnt_o), 32'd0);
    @(negedge clk);

    // Table-driven sequences; vecs[4] follows the held request of vecs[3]
    // so it is accepted on the very first IDLE cycle.
    for (int i = 0; i < 8; i++) run_seq(vecs[i]);

    // Reset mid-RUN with ratio 5: ticks at rel 6, 11; reset lands on rel 11.
    c1.cfg_valid_i = 1'b1; c1.cfg_ratio_i = 32'd5; c1.cfg_count_i = 16'd0;
    @(posedge clk);
    t = 0;
    for (int rel = 1; rel <= 10; rel++) begin
      @(negedge clk);
      c1.cfg_valid_i = 1'b0;
      if (c1.tick_o) t++;
    end
    chk("mid_ticks", 32'(t), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstcyc_tick", 32'(c1.tick_o), 32'd0);
    chk("rstcyc_done", 32'(c1.done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_rst_ready", 32'(c1.cfg_ready_o), 32'd1);
    chk("after_rst_busy",  32'(c1.busy_o), 32'd0);
    chk("after_rst_cnt",   32'(c1.tick_cnt_o), 32'd0);
    t = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c1.tick_o || c1.done_o || c1.busy_o) t++;
    end
    chk("after_rst_quiet", 32'(t), 32'd0);
    run_seq('{"post_rst", 32'd5, 16'd2, 0, 2, 1'b0});

    // COUNT_WIDTH=4 continuous ratio 1: 17 RUN cycles wrap the count to 1.
    c2.cfg_valid_i = 1'b1; c2.cfg_ratio_i = 32'd1; c2.cfg_count_i = 4'd0;
    @(posedge clk);
    @(negedge clk);
    c2.cfg_valid_i = 1'b0;
    chk("w_load_tick", 32'(c2.tick_o), 32'd0);
    t = 0;
    for (int run = 1; run <= 17; run++) begin
      @(negedge clk);
      if (c2.tick_o) t++;
      if (run == 17) begin
        chk("w_cnt16", 32'(c2.tick_cnt_o), 32'd0);
        c2.stop_i = 1'b1;
      end
    end
    chk("w_ticks", 32'(t), 32'd17);
    @(negedge clk);
    c2.stop_i = 1'b0;
    chk("w_done", 32'(c2.done_o), 32'd1);
    chk("w_cnt",  32'(c2.tick_cnt_o), 32'd1);
    chk("w_tick_fin", 32'(c2.tick_o), 32'd0);
    @(negedge clk);
    chk("w_idle_ready", 32'(c2.cfg_ready_o), 32'd1);
    chk("w_idle_cnt",   32'(c2.tick_cnt_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter RATIO_WIDTH, default 32, width of the divider ratio.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of the tick-count request and the tick counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_valid_i  input  1  configuration request valid.
REQ-006 SHALL have port cfg_ready_o  output  1  controller accepts a configuration.
REQ-007 SHALL have port cfg_ratio_i  input  RATIO_WIDTH  requested divide ratio.
REQ-008 SHALL have port cfg_count_i  input  COUNT_WIDTH  number of ticks to emit; 0 means continuous.
REQ-009 SHALL have port stop_i  input  1  abort request for the running sequence.
REQ-010 SHALL have port tick_o  output  1  divided tick, one-cycle pulse.
REQ-011 SHALL have port busy_o  output  1  a sequence is in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse at sequence end.
REQ-013 SHALL have port tick_cnt_o  output  COUNT_WIDTH  ticks emitted in the current or last sequence.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, FINISH.
REQ-015 SHALL drive cfg_ready_o high only in IDLE.
REQ-016 SHALL accept a configuration on any cycle where cfg_valid_i and cfg_ready_o are both high, then enter LOAD.
REQ-017 SHALL latch ratio and count on acceptance, clear tick_cnt_o to 0, and clamp ratio 0 to 1.
REQ-018 SHALL hold the latched ratio constant until the next acceptance; cfg_* changes outside acceptance have no effect.
REQ-019 SHALL stay in LOAD exactly one cycle with the divider disabled and its counter cleared, then enter RUN.
REQ-020 SHALL enable the divider in RUN only, with its counter at 0 in the first RUN cycle.
REQ-021 SHALL assert tick_o combinationally when the divider is enabled and its counter equals ratio-1, then wrap the counter to 0.
  - Ticks therefore occur on RUN cycles ratio, 2*ratio, ... (1-indexed); ratio 1 gives a tick on every RUN cycle.
REQ-022 SHALL increment tick_cnt_o on every tick, wrapping modulo 2^COUNT_WIDTH in continuous mode.
REQ-023 SHALL, when count != 0, enter FINISH on the cycle after the tick that makes tick_cnt_o equal count.
REQ-024 SHALL, when stop_i is high in RUN, enter FINISH next cycle.
  - A tick coinciding with stop_i is still output and counted.
  - stop_i SHALL be ignored in IDLE, LOAD and FINISH.
REQ-025 SHALL assert done_o for exactly the single FINISH cycle, then return to IDLE.
REQ-026 SHALL drive busy_o high in LOAD, RUN and FINISH, and low in IDLE.
REQ-027 SHALL hold tick_cnt_o at its final value in IDLE until the next acceptance.
REQ-028 SHALL never assert tick_o outside RUN.

Reset
REQ-029 SHALL, on a rising clk_i edge with rst_ni low, enter IDLE and clear the divider counter, latched ratio, latched count and tick_cnt_o to 0.
REQ-030 SHALL have reset values tick_o=0, done_o=0, busy_o=0, cfg_ready_o=1 in the first cycle after rst_ni deasserts.
REQ-031 SHALL, on reset mid-sequence, abort without a done_o pulse and emit no tick in the reset cycle.

Structure
REQ-032 SHALL place the FSM state enum and default RATIO_WIDTH/COUNT_WIDTH constants in shared package clk_div_ctrl_pkg.
REQ-033 SHALL implement the divider as sub-module tick_div (clk_i, rst_ni, en_i, clr_i, ratio_i, tick_o), using synchronous active-low reset and a counter cleared by clr_i.

Verification
REQ-034 SHALL cover: ratio=4, count=3 -> ticks on RUN cycles 4, 8, 12; done_o one cycle after the third tick; tick_cnt_o=3; cfg_ready_o high the following cycle.
REQ-035 SHALL cover: ratio=0, count=5 -> treated as ratio 1; ticks on 5 consecutive RUN cycles; tick_cnt_o=5.
REQ-036 SHALL cover: ratio=3, count=0, stop_i pulsed on the 7th tick cycle -> 7 ticks, tick_cnt_o=7, done_o next cycle, no further ticks.
REQ-037 SHALL cover: cfg_valid_i held high with new values during RUN -> not accepted; accepted on the first IDLE cycle with the new ratio.
REQ-038 SHALL cover: rst_ni low for one cycle mid-RUN (ratio=5) -> IDLE, tick_cnt_o=0, no done_o, no tick_o until a new configuration is accepted.
REQ-039 SHALL cover: COUNT_WIDTH=4, continuous mode, ratio=1, 17 RUN cycles -> tick_cnt_o wraps to 1.
